// File: rtl/auth_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : auth_cmd_tx
// Description : Serializes authorization command bytes over an 8N1 UART link.
//               A go request sends GO_BYTE and a stop request sends
//               STOP_BYTE. Includes a baud counter, a one-deep pending
//               command slot and arbitration that gives stop priority.
//
//               Optional feature macro: AUTH_TX_KEEPALIVE_EN
//                 When defined, the block resends GO_BYTE after
//                 KEEPALIVE_CYC idle clocks while pwr_cmd is 1.
//
// Ports       : clk      - system clock, rising edge
//               rst_n    - synchronous active-low reset
//               go_req   - single-cycle request to send GO_BYTE
//               stop_req - single-cycle request to send STOP_BYTE
//               TX       - serial line, idles high
//               busy     - high while a frame is on the line
//               done     - one-cycle pulse in the last clock of a stop bit
//               pwr_cmd  - 1 after a GO frame, 0 after a STOP frame
// Revision    : 1.0 - initial release
// ============================================================================
module auth_cmd_tx #(
    parameter int          BAUD_DIV      = 2604,
    parameter logic [7:0]  GO_BYTE       = 8'h67,
    parameter logic [7:0]  STOP_BYTE     = 8'h73,
    parameter logic [23:0] KEEPALIVE_CYC = 24'd5_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic go_req,
    input  logic stop_req,
    output logic TX,
    output logic busy,
    output logic done,
    output logic pwr_cmd
);

    localparam logic [11:0] c_baud_last = 12'(BAUD_DIV - 1);
    localparam logic [11:0] c_baud_pre  = 12'(BAUD_DIV - 2);
    localparam logic [3:0]  c_bit_last  = 4'd9;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_XMIT = 1'b1
    } state_t;

    state_t      r_state;
    logic [11:0] r_baud;
    logic [3:0]  r_bit;
    logic [8:0]  r_shift;      // data bits then stop bit, LSB goes out next
    logic        r_cur_stop;   // frame on the line is a STOP frame
    logic        r_pend_valid;
    logic        r_pend_stop;

    logic w_ka_trig;
    logic w_go;
    logic w_any;
    logic w_baud_wrap;
    logic w_frame_end;
    logic w_m_valid;
    logic w_m_stop;

    assign w_go        = go_req | w_ka_trig;
    assign w_any       = w_go | stop_req;
    assign w_baud_wrap = (r_baud == c_baud_last);
    assign w_frame_end = w_baud_wrap && (r_bit == c_bit_last);

    // Pending slot merged with this cycle's requests: stop always wins, a go
    // never displaces a pending stop, and a repeat of the pending command
    // collapses into the existing entry.
    assign w_m_valid = r_pend_valid | w_any;
    assign w_m_stop  = stop_req | (r_pend_valid & r_pend_stop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_baud       <= '0;
            r_bit        <= '0;
            r_shift      <= '1;
            r_cur_stop   <= 1'b0;
            r_pend_valid <= 1'b0;
            r_pend_stop  <= 1'b0;
            TX           <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            pwr_cmd      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    TX   <= 1'b1;
                    busy <= 1'b0;
                    if (w_any) begin
                        // Start bit goes out on this edge; a simultaneous go
                        // is dropped in favour of the stop.
                        r_state    <= S_XMIT;
                        busy       <= 1'b1;
                        TX         <= 1'b0;
                        r_baud     <= '0;
                        r_bit      <= '0;
                        r_cur_stop <= stop_req;
                        r_shift    <= {1'b1, (stop_req ? STOP_BYTE : GO_BYTE)};
                    end
                end

                S_XMIT: begin
                    if (!w_baud_wrap) begin
                        r_baud       <= r_baud + 12'd1;
                        r_pend_valid <= w_m_valid;
                        r_pend_stop  <= w_m_stop;
                        // Registered one clock early so it lines up with the
                        // final clock of the stop bit.
                        done <= (r_bit == c_bit_last) && (r_baud == c_baud_pre);
                    end else if (!w_frame_end) begin
                        r_baud       <= '0;
                        r_bit        <= r_bit + 4'd1;
                        TX           <= r_shift[0];
                        r_shift      <= {1'b1, r_shift[8:1]};
                        r_pend_valid <= w_m_valid;
                        r_pend_stop  <= w_m_stop;
                    end else begin
                        pwr_cmd      <= ~r_cur_stop;
                        r_baud       <= '0;
                        r_bit        <= '0;
                        r_pend_valid <= 1'b0;
                        r_pend_stop  <= 1'b0;
                        if (w_m_valid) begin
                            // Back-to-back: next start bit with no idle gap,
                            // including a request arriving in this very cycle.
                            TX         <= 1'b0;
                            r_cur_stop <= w_m_stop;
                            r_shift    <= {1'b1, (w_m_stop ? STOP_BYTE : GO_BYTE)};
                        end else begin
                            r_state <= S_IDLE;
                            TX      <= 1'b1;
                            busy    <= 1'b0;
                        end
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    TX      <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

`ifdef AUTH_TX_KEEPALIVE_EN
    localparam logic [23:0] c_ka_last = KEEPALIVE_CYC - 24'd1;

    logic [23:0] r_idle_cnt;

    assign w_ka_trig = (r_state == S_IDLE) && pwr_cmd && (r_idle_cnt == c_ka_last);

    // Counts idle clocks only while power is on; any accepted request
    // (including the self-issued one) restarts the interval.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idle_cnt <= '0;
        end else if ((r_state != S_IDLE) || !pwr_cmd || w_any) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 24'd1;
        end
    end
`else
    logic w_unused_keepalive;

    assign w_ka_trig          = 1'b0;
    assign w_unused_keepalive = ^KEEPALIVE_CYC;
`endif

endmodule
`default_nettype wire

// File: tb/tb_auth_cmd_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_auth_cmd_tx
// Description : Self-checking bench for auth_cmd_tx with BAUD_DIV=16.
//               Stimulus pushes expected frames into a scoreboard queue; a
//               monitor decodes TX and compares each frame as it completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_auth_cmd_tx;

    localparam int BAUD = 16;

    logic clk = 1'b0;
    logic rst_n;
    logic go_req;
    logic stop_req;
    logic TX;
    logic busy;
    logic done;
    logic pwr_cmd;

    typedef struct {
        logic [7:0] b;
        logic       pwr;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    bit   mon_en   = 1'b0;
    int   cur_run  = 0;
    int   last_run = 0;

    auth_cmd_tx #(
        .BAUD_DIV     (BAUD),
        .GO_BYTE      (8'h67),
        .STOP_BYTE    (8'h73),
        .KEEPALIVE_CYC(24'd200)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .go_req  (go_req),
        .stop_req(stop_req),
        .TX      (TX),
        .busy    (busy),
        .done    (done),
        .pwr_cmd (pwr_cmd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expect_frame(input logic [7:0] b, input logic pwr);
        exp_t e;
        e.b   = b;
        e.pwr = pwr;
        sb_q.push_back(e);
    endtask

    task automatic pulse(input logic g, input logic s);
        @(posedge clk);
        #1;
        go_req   = g;
        stop_req = s;
        @(posedge clk);
        #1;
        go_req   = 1'b0;
        stop_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0) begin
            if (n >= budget) begin
                checks++;
                failures++;
                $display("FAIL wait_idle timeout actual=busy required=idle");
                return;
            end
            n++;
            @(negedge clk);
        end
        repeat (3) @(negedge clk);
    endtask

    // Length of the most recent contiguous busy run, in clocks.
    always @(negedge clk) begin
        if (busy === 1'b1) begin
            cur_run++;
        end else if (cur_run != 0) begin
            last_run = cur_run;
            cur_run  = 0;
        end
    end

    // Monitor: decode each frame mid-bit and compare against the scoreboard.
    initial begin : monitor
        logic [9:0] fr;
        logic       d158;
        logic       d159;
        bit         aborted;
        exp_t       e;
        @(negedge clk);
        forever begin
            if (!(mon_en && TX === 1'b0)) begin
                @(negedge clk);
            end else begin
                aborted = 1'b0;
                fr      = '0;
                d158    = 1'b0;
                d159    = 1'b0;
                for (int i = 0; i < 10 * BAUD; i++) begin
                    if (rst_n !== 1'b1) begin
                        aborted = 1'b1;
                        break;
                    end
                    if (i % BAUD == BAUD / 2) fr[i / BAUD] = TX;
                    if (i == 10 * BAUD - 2) d158 = done;
                    if (i == 10 * BAUD - 1) d159 = done;
                    if (i < 10 * BAUD - 1) @(negedge clk);
                end
                if (aborted) begin
                    @(negedge clk);
                end else begin
                    @(negedge clk);
                    if (sb_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame actual=%0h required=none", fr[8:1]);
                    end else begin
                        e = sb_q.pop_front();
                        chk("frame_byte", 32'(fr[8:1]), 32'(e.b));
                        chk("start_bit", 32'(fr[0]), 32'd0);
                        chk("stop_bit", 32'(fr[9]), 32'd1);
                        chk("done_early", 32'(d158), 32'd0);
                        chk("done_last_clk", 32'(d159), 32'd1);
                        chk("done_after", 32'(done), 32'd0);
                        chk("pwr_cmd", 32'(pwr_cmd), 32'(e.pwr));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit saw_busy;
        rst_n    = 1'b0;
        go_req   = 1'b0;
        stop_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pwr", 32'(pwr_cmd), 32'd0);
        rst_n  = 1'b1;
        mon_en = 1'b1;
        repeat (5) @(posedge clk);

        // Single GO frame, one-clock acceptance latency.
        expect_frame(8'h67, 1'b1);
        pulse(1'b1, 1'b0);
        chk("lat_tx", 32'(TX), 32'd0);
        chk("lat_busy", 32'(busy), 32'd1);
        wait_idle(400);
        chk("run_go", 32'(last_run), 32'(10 * BAUD));

        // Simultaneous go and stop: only STOP is sent.
        expect_frame(8'h73, 1'b0);
        pulse(1'b1, 1'b1);
        wait_idle(400);
        chk("run_gostop", 32'(last_run), 32'(10 * BAUD));

        // Stop arriving at bit 4 of a GO frame: back-to-back frames.
        expect_frame(8'h67, 1'b1);
        expect_frame(8'h73, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (4 * BAUD) @(posedge clk);
        pulse(1'b0, 1'b1);
        wait_idle(800);
        chk("run_b2b", 32'(last_run), 32'(20 * BAUD));

        // Stop then go while transmitting: the go is dropped.
        expect_frame(8'h67, 1'b1);
        expect_frame(8'h73, 1'b0);
        pulse(1'b1, 1'b0);
        repeat (2 * BAUD) @(posedge clk);
        pulse(1'b0, 1'b1);
        repeat (BAUD) @(posedge clk);
        pulse(1'b1, 1'b0);
        wait_idle(800);
        chk("run_stop_go", 32'(last_run), 32'(20 * BAUD));

        // Two go requests during a STOP frame collapse into one GO frame.
        expect_frame(8'h73, 1'b0);
        expect_frame(8'h67, 1'b1);
        pulse(1'b0, 1'b1);
        repeat (BAUD) @(posedge clk);
        pulse(1'b1, 1'b0);
        repeat (3 * BAUD) @(posedge clk);
        pulse(1'b1, 1'b0);
        wait_idle(800);
        chk("run_go_absorb", 32'(last_run), 32'(20 * BAUD));

        // Go request sampled in the done cycle is sent back-to-back.
        expect_frame(8'h73, 1'b0);
        expect_frame(8'h67, 1'b1);
        pulse(1'b0, 1'b1);
        repeat (10 * BAUD - 2) @(posedge clk);
        #1;
        go_req = 1'b1;
        @(posedge clk);
        #1;
        go_req = 1'b0;
        wait_idle(800);
        chk("run_done_req", 32'(last_run), 32'(20 * BAUD));

        // Reset at bit 5 of a frame, with a stop pending.
        pulse(1'b1, 1'b0);
        repeat (BAUD) @(posedge clk);
        pulse(1'b0, 1'b1);
        repeat (4 * BAUD + 4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_tx", 32'(TX), 32'd1);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pwr", 32'(pwr_cmd), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n    = 1'b1;
        saw_busy = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || TX !== 1'b1 || done !== 1'b0) saw_busy = 1'b1;
        end
        chk("abort_no_pending", 32'(saw_busy), 32'd0);

        // Recovery after reset.
        expect_frame(8'h67, 1'b1);
        pulse(1'b1, 1'b0);
        wait_idle(400);
        chk("run_recover", 32'(last_run), 32'(10 * BAUD));

        repeat (20) @(posedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/auth_cmd_tx.md
Name: auth_cmd_tx

Overview:
- Phone/controller-side counterpart to the rider authorization receiver.
- Serializes authorization command bytes over a UART link: "go" (8'h67) powers up the platform, "stop" (8'h73) requests power-down.
- Contains its own 8N1 serializer with baud counter, a one-deep pending-command slot and stop-priority arbitration.
- Used in the full-chip testbench and on the companion FPGA to drive the platform's RX line.

Parameters:
- BAUD_DIV, 2604, clocks per bit (50 MHz / 19200 baud); legal range 2..4095.
- GO_BYTE, 8'h67, byte sent for a go request.
- STOP_BYTE, 8'h73, byte sent for a stop request.
- KEEPALIVE_CYC, 24'd5_000_000, idle clocks between keepalive go resends; used only with the optional feature.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- go_req  input  1  single-cycle request to send GO_BYTE.
- stop_req  input  1  single-cycle request to send STOP_BYTE.
- TX  output  1  serial line; idles high.
- busy  output  1  high while a frame is on the line.
- done  output  1  one-cycle pulse in the last clock of each stop bit.
- pwr_cmd  output  1  1 after a GO frame completes, 0 after a STOP frame completes.

Behaviour:
- Reset (rst_n low at a clk edge):
  - TX=1, busy=0, done=0, pwr_cmd=0.
  - Pending slot empty, state IDLE, baud and bit counters cleared.
  - A reset asserted mid-frame aborts the frame; TX returns high on the next edge.
- States:
  - IDLE: TX=1.
  - XMIT: shifting a 10-bit frame of start bit 0, data LSB first, stop bit 1.
- Frame timing:
  - Each bit lasts exactly BAUD_DIV clocks; a full frame lasts 10*BAUD_DIV clocks.
  - A baud counter counts 0..BAUD_DIV-1.
  - A 4-bit bit counter counts 0..9; the shift register advances when the baud counter wraps.
- Acceptance in IDLE:
  - A request sampled at edge N makes TX=0 and busy=1 from edge N+1, so latency is 1 clock.
  - If go_req and stop_req arrive in the same cycle, STOP wins and the go is dropped.
- Request during XMIT:
  - The request is stored in the one-deep pending slot.
  - A stop request overwrites a pending go.
  - A go request never overwrites a pending stop.
  - A request matching the pending command is absorbed; no duplicate frame is sent.
- End of frame:
  - done=1 for the final clock of the stop bit.
  - pwr_cmd updates on that same edge: GO frame sets it to 1, STOP frame sets it to 0.
  - If the slot is pending, the next start bit begins on the following clock, so busy stays high with no idle gap. The slot clears on load.
  - Otherwise the block returns to IDLE and busy=0.
- Request coinciding with the done cycle: treated as pending and transmitted back-to-back.
- No request is ever lost except:
  - the go in a simultaneous go/stop pair;
  - a go issued while a stop is pending.

Optional Feature:
- Macro: AUTH_TX_KEEPALIVE_EN.
- Defined:
  - While pwr_cmd=1 and the block is IDLE, a 24-bit idle counter increments each clock.
  - On reaching KEEPALIVE_CYC-1, the block self-issues a go request, resends GO_BYTE and clears the counter.
  - The counter clears on any accepted request, while busy, when pwr_cmd=0, and on reset.
  - A stop_req arriving on the same cycle as the keepalive trigger wins.
- Undefined:
  - No counter is synthesized and KEEPALIVE_CYC is ignored.
  - Frames are sent only on explicit requests.

Test Plan:
- BAUD_DIV=16 for all tests. Reset, then go_req pulse at cycle 10:
  - TX=0 for cycles 11-26, then data bits 1,1,1,0,0,1,1,0 at 16 clocks each.
  - TX=1 for the stop bit; done pulses at cycle 170; pwr_cmd=1 from cycle 171.
  - Checked by looping back into the platform's UART receiver, which must receive 8'h67.
- go_req and stop_req in the same cycle:
  - Exactly one frame (8'h73) is sent; pwr_cmd stays 0.
- go_req, then stop_req at bit 4 of that frame:
  - Frames 8'h67 and 8'h73 are sent back-to-back.
  - busy never drops between them; done pulses twice, 160 clocks apart; final pwr_cmd=0.
- During a frame, stop_req then go_req:
  - The second frame is 8'h73 only; the go is not sent.
- Assert rst_n=0 at bit 5 of a frame:
  - TX=1, busy=0 and pwr_cmd=0 on the next edge; no done pulse; the pending slot is empty.
- With AUTH_TX_KEEPALIVE_EN and KEEPALIVE_CYC=200, after one GO frame:
  - A second 8'h67 frame starts 200 clocks after busy falls.
  - With a stop_req before the timeout, no keepalive is sent.
